// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: deals a sof-framed serial word stream
// onto four lane registers and publishes each complete frame with a pulse.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       sel, sel_nx;
    logic [WIDTH-1:0] shadow0, shadow1, shadow2;
    logic [WIDTH-1:0] shadow0_nx, shadow1_nx, shadow2_nx;
    logic [WIDTH-1:0] out0_nx, out1_nx, out2_nx, out3_nx;
    logic             out_valid_nx, frame_err_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'd0;
            shadow0   <= '0;
            shadow1   <= '0;
            shadow2   <= '0;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            shadow0   <= shadow0_nx;
            shadow1   <= shadow1_nx;
            shadow2   <= shadow2_nx;
            out0      <= out0_nx;
            out1      <= out1_nx;
            out2      <= out2_nx;
            out3      <= out3_nx;
            out_valid <= out_valid_nx;
            frame_err <= frame_err_nx;
        end
    end

    // busy comes straight off the state flop, so it is glitch-free
    assign busy = (state == RECV);

    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        shadow0_nx   = shadow0;
        shadow1_nx   = shadow1;
        shadow2_nx   = shadow2;
        out0_nx      = out0;
        out1_nx      = out1;
        out2_nx      = out2;
        out3_nx      = out3;
        out_valid_nx = 1'b0;
        frame_err_nx = 1'b0;

        unique case (state)
            IDLE: begin
                if (in_valid && in_sof) begin
                    shadow0_nx = in_data;
                    sel_nx     = 2'd1;
                    state_nx   = RECV;
                end
            end
            RECV: begin
                if (in_valid && in_sof) begin
                    // a new sof restarts the frame; the partial one is lost
                    frame_err_nx = 1'b1;
                    shadow0_nx   = in_data;
                    sel_nx       = 2'd1;
                end else if (in_valid) begin
                    if (sel == 2'd3) begin
                        out0_nx      = shadow0;
                        out1_nx      = shadow1;
                        out2_nx      = shadow2;
                        out3_nx      = in_data;
                        out_valid_nx = 1'b1;
                        sel_nx       = 2'd0;
                        state_nx     = IDLE;
                    end else begin
                        unique case (sel)
                            2'd0:    shadow0_nx = in_data;
                            2'd1:    shadow1_nx = in_data;
                            default: shadow2_nx = in_data;
                        endcase
                        sel_nx = sel + 2'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 with hand-computed expectations.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] out0, out1, out2, out3;
    logic       out_valid, busy, frame_err;

    int n_cmp = 0;
    int n_err = 0;

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e0,
                           input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3);
        chk({tag, ".outs"}, {out0, out1, out2, out3}, {e0, e1, e2, e3});
    endtask

    task automatic chk_fl(input string tag, input logic ov,
                          input logic bz, input logic fe);
        chk({tag, ".flags"}, {29'd0, out_valid, busy, frame_err},
            {29'd0, ov, bz, fe});
    endtask

    // inputs change and outputs are sampled 1 ns after each rising edge
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk_out("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        chk_fl("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: basic frame
        step(1, 1, 8'hA1);
        chk_fl("t1.w0", 0, 1, 0);
        step(1, 0, 8'hB2);
        chk_fl("t1.w1", 0, 1, 0);
        step(1, 0, 8'hC3);
        chk_fl("t1.w2", 0, 1, 0);
        chk_out("t1.w2", 8'h00, 8'h00, 8'h00, 8'h00);
        step(1, 0, 8'hD4);
        chk_fl("t1.done", 1, 0, 0);
        chk_out("t1.done", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        step(0, 0, 8'h00);
        chk_fl("t1.after", 0, 0, 0);

        // 2: same frame with 3-cycle gaps
        step(1, 1, 8'hA1);
        for (int g = 0; g < 3; g++) begin
            step(0, 1, 8'hFF);
            chk_fl("t2.gap0", 0, 1, 0);
        end
        step(1, 0, 8'hB2);
        for (int g = 0; g < 3; g++) begin
            step(0, 0, 8'h00);
            chk_fl("t2.gap1", 0, 1, 0);
        end
        step(1, 0, 8'hC3);
        for (int g = 0; g < 3; g++) begin
            step(0, 0, 8'h00);
            chk_fl("t2.gap2", 0, 1, 0);
        end
        step(1, 0, 8'hD4);
        chk_fl("t2.done", 1, 0, 0);
        chk_out("t2.done", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        step(0, 0, 8'h00);
        chk_fl("t2.after", 0, 0, 0);

        // 3: words without sof while idle are dropped
        step(1, 0, 8'h55);
        chk_fl("t3.w0", 0, 0, 0);
        step(1, 0, 8'h66);
        chk_fl("t3.w1", 0, 0, 0);
        chk_out("t3", 8'hA1, 8'hB2, 8'hC3, 8'hD4);

        // 4: sof mid-frame
        step(1, 1, 8'h11);
        step(1, 0, 8'h22);
        step(1, 1, 8'h31);
        chk_fl("t4.err", 0, 1, 1);
        chk_out("t4.err", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        step(1, 0, 8'h32);
        chk_fl("t4.w1", 0, 1, 0);
        step(1, 0, 8'h33);
        step(1, 0, 8'h34);
        chk_fl("t4.done", 1, 0, 0);
        chk_out("t4.done", 8'h31, 8'h32, 8'h33, 8'h34);

        // 5: back-to-back frames
        step(1, 1, 8'h41);
        chk_fl("t5.a0", 0, 1, 0);
        step(1, 0, 8'h42);
        step(1, 0, 8'h43);
        step(1, 0, 8'h44);
        chk_fl("t5.adone", 1, 0, 0);
        chk_out("t5.adone", 8'h41, 8'h42, 8'h43, 8'h44);
        step(1, 1, 8'h51);
        chk_fl("t5.b0", 0, 1, 0);
        step(1, 0, 8'h52);
        chk_fl("t5.b1", 0, 1, 0);
        step(1, 0, 8'h53);
        chk_fl("t5.b2", 0, 1, 0);
        step(1, 0, 8'h54);
        chk_fl("t5.bdone", 1, 0, 0);
        chk_out("t5.bdone", 8'h51, 8'h52, 8'h53, 8'h54);
        step(0, 0, 8'h00);
        chk_fl("t5.after", 0, 0, 0);

        // 6: async reset mid-frame, then a clean frame
        step(1, 1, 8'h61);
        step(1, 0, 8'h62);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_out("t6.rst", 8'h00, 8'h00, 8'h00, 8'h00);
        chk_fl("t6.rst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 0, 8'h63);
        chk_fl("t6.stale", 0, 0, 0);
        step(1, 1, 8'h01);
        step(1, 0, 8'h02);
        step(1, 0, 8'h03);
        step(1, 0, 8'h04);
        chk_fl("t6.done", 1, 0, 0);
        chk_out("t6.done", 8'h01, 8'h02, 8'h03, 8'h04);
        step(0, 0, 8'h00);
        chk_fl("t6.after", 0, 0, 0);
        chk_out("t6.hold", 8'h01, 8'h02, 8'h03, 8'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
